// File: rtl/sdram_apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_apb_arbiter_if
// One APB link: request fields flow master -> slave, response slave -> master.
//   master : drives paddr/psel/penable/pprot/pwrite/pwdata/pstrb, reads response
//   slave  : reads request, drives pready/prdata/pslverr
// -----------------------------------------------------------------------------
interface sdram_apb_arbiter_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/sdram_apb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_apb_arbiter
// Shares the single APB slave port of the SDRAM wrapper between two requesters.
// One registered downstream transfer per grant; the response goes to the winner.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high
//   in0/in1  : requester links (arbiter is their slave)
//   out      : link to the SDRAM wrapper (arbiter is its master)
//   grant_id : current or last winner
//   FIXED_PRIO = 0 round-robin tie break, 1 port 0 always wins a tie
// -----------------------------------------------------------------------------
module sdram_apb_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    sdram_apb_arbiter_if.slave         in0,
    sdram_apb_arbiter_if.slave         in1,
    sdram_apb_arbiter_if.master        out,
    output logic                       grant_id
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_last;
    logic        r_grant;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic [2:0]  r_pprot;
    logic        r_pwrite;
    logic [3:0]  r_pstrb;
    logic [31:0] r_prdata;
    logic        r_pslverr;

    logic [1:0]  w_req;
    logic        w_win;
    logic        w_resp0;
    logic        w_resp1;

    // Winner selection; only meaningful while at least one psel is high.
    always_comb begin
        w_req = {in1.psel, in0.psel};
        w_win = 1'b0;
        if (w_req == 2'b11)
            w_win = FIXED_PRIO ? 1'b0 : ~r_last;
        else
            w_win = w_req[1];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req != 2'b00) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (out.pready) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;   // port 0 wins the first tie
            r_grant   <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pprot   <= '0;
            r_pwrite  <= 1'b0;
            r_pstrb   <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_state <= w_next;
            // Request is frozen at grant; later requester changes are ignored.
            if (r_state == IDLE && w_req != 2'b00) begin
                r_grant  <= w_win;
                r_paddr  <= w_win ? in1.paddr  : in0.paddr;
                r_pwdata <= w_win ? in1.pwdata : in0.pwdata;
                r_pprot  <= w_win ? in1.pprot  : in0.pprot;
                r_pwrite <= w_win ? in1.pwrite : in0.pwrite;
                r_pstrb  <= w_win ? in1.pstrb  : in0.pstrb;
            end
            // pready outside ACCESS is not a completion.
            if (r_state == ACCESS && out.pready) begin
                r_prdata  <= out.prdata;
                r_pslverr <= out.pslverr;
            end
            if (r_state == RESP)
                r_last <= r_grant;
        end
    end

    // Downstream: control decoded from state, fields straight from holding regs.
    assign out.psel    = (r_state == SETUP) || (r_state == ACCESS);
    assign out.penable = (r_state == ACCESS);
    assign out.paddr   = r_paddr;
    assign out.pwdata  = r_pwdata;
    assign out.pprot   = r_pprot;
    assign out.pwrite  = r_pwrite;
    assign out.pstrb   = r_pstrb;

    // Upstream: only the winner sees a response, and only in RESP.
    assign w_resp0 = (r_state == RESP) && !r_grant;
    assign w_resp1 = (r_state == RESP) &&  r_grant;

    assign in0.pready  = w_resp0;
    assign in0.prdata  = w_resp0 ? r_prdata : 32'h0;
    assign in0.pslverr = w_resp0 & r_pslverr;
    assign in1.pready  = w_resp1;
    assign in1.prdata  = w_resp1 ? r_prdata : 32'h0;
    assign in1.pslverr = w_resp1 & r_pslverr;

    assign grant_id = r_grant;

endmodule

// File: doc/sdram_apb_arbiter.md
# sdram_apb_arbiter

Two-port APB arbiter sharing the single APB slave port of the SDRAM controller wrapper between two requesters, e.g. CPU LSU on port 0 and DMA engine on port 1. Each requester sees an APB slave. The arbiter presents one registered APB master to the SDRAM wrapper, selects a winner round-robin or by fixed priority, and runs exactly one downstream transfer per grant. It returns the response to the winner only.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = port 0 always wins a tie.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in0_paddr`/`in1_paddr` in 32; `inN_psel` in 1; `inN_penable` in 1; `inN_pprot` in 3; `inN_pwrite` in 1; `inN_pwdata` in 32; `inN_pstrb` in 4: requester APB request, N = 0, 1.
- `inN_pready` out 1; `inN_prdata` out 32; `inN_pslverr` out 1: requester APB response.
- `out_paddr` out 32; `out_psel` out 1; `out_penable` out 1; `out_pprot` out 3; `out_pwrite` out 1; `out_pwdata` out 32; `out_pstrb` out 4: to the SDRAM wrapper.
- `out_pready` in 1; `out_prdata` in 32; `out_pslverr` in 1: from the SDRAM wrapper.
- `grant_id` out 1: index of the current or last winner (debug/perf).

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - Request N is pending when `inN_psel`=1.
  - If none is pending, stay in IDLE.
  - If exactly one is pending, it wins.
  - If both are pending and `FIXED_PRIO`=1, port 0 wins.
  - If both are pending and `FIXED_PRIO`=0, the port not equal to `last` wins.
  - On a win, on the clock edge: capture the winner's paddr, pwrite, pwdata, pstrb and pprot into holding registers; set `grant_id` to the winner; go to SETUP.
- **SETUP**
  - Drive `out_psel`=1, `out_penable`=0 and all `out_*` request fields from the holding registers.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - Drive `out_psel`=1 and `out_penable`=1; the request fields stay stable.
  - Wait for `out_pready`=1. On that edge, capture `out_prdata` and `out_pslverr`, then go to RESP.
  - No timeout.
- **RESP**
  - `out_psel`=0 and `out_penable`=0.
  - Drive `in{grant_id}_pready`=1 for exactly one cycle, with `prdata`/`pslverr` taken from the captured response.
  - Set `last`=`grant_id` and go to IDLE.
- Response outputs of the non-granted port, and of both ports outside RESP, are `pready`=0, `prdata`=0, `pslverr`=0.
- The requester holds its signals through the wait states, per APB rules. The arbiter ignores the requester's `penable` and its field changes after capture.
- Write data and strobes pass through unmodified. `out_pstrb` is forwarded even for reads; the downstream wrapper masks it.

## Timing
- Reset values: IDLE; `last`=1, so port 0 wins the first tie. `grant_id`=0. All outputs 0.
- All `out_*` and `inN_*` outputs are registered or decoded from the state only. There is no combinational path from `inN_*` to `out_*`, nor from `out_*` inputs to `inN_*`.
- Latency, with request visible in IDLE at cycle 0 and downstream `out_pready` returned in ACCESS after W wait cycles:
  - SETUP is cycle 1.
  - ACCESS spans cycles 2 to 2+W.
  - RESP is cycle 3+W, when the requester sees `pready`.
  - Minimum latency is 3 cycles.
- Back-to-back: IDLE follows RESP, so the next grant is sampled at cycle 4+W. The minimum downstream transfer pitch is 4 cycles.
- Starvation bound (round-robin): a pending port waits at most one full transfer of the other port.
- Boundary cases:
  - **Requester drops `psel` after winning** (protocol violation): the downstream transfer still completes. RESP still pulses the port's `pready`, and the port ignores it.
  - **New request from the just-served port:** may appear in the IDLE cycle after RESP. It is arbitrated normally against the other port, and `last` disfavours it in a tie.
  - **`out_pready` asserted outside ACCESS:** ignored.
  - **`out_pslverr`=1:** forwarded once in RESP; no retry.
  - **Reset mid-transfer:** all outputs drop to 0 in the same cycle (asynchronous). The SDRAM wrapper shares this reset, so no transfer is left outstanding.

## Test plan
- **Single port-0 read:** after reset, assert a port-0 read at 0x8000_0010 with downstream W=2 and `out_prdata`=0xDEAD_BEEF.
  - Expect `out_psel` in cycle 1 and `out_penable` in cycles 2–4.
  - Expect `in0_pready` in cycle 5 only, with `in0_prdata`=0xDEAD_BEEF; `in1_*` stay 0.
- **Simultaneous requests, `FIXED_PRIO`=0:** both ports request in the same cycle, twice in a row.
  - Expect grant order 0, 1, 0, 1.
  - `grant_id` matches each downstream transfer's captured address.
- **Simultaneous requests, `FIXED_PRIO`=1:** both ports request continuously.
  - Port 0 is served each time; port 1 is served only when port 0 deasserts.
- **Port-1 write:** `paddr`=0x8000_0100, `pwdata`=0x1234_5678, `pstrb`=4'b0110.
  - `out_*` carry exactly these values, stable from SETUP through ACCESS.
  - `in1_pready` pulses once.
- **Slave error:** `out_pslverr`=1 with `out_pready`.
  - Requester sees `pslverr`=1 together with `pready`; the next transfer shows `pslverr`=0.
- **Reset mid-transfer:** assert `reset` in ACCESS.
  - `out_psel`/`out_penable` are 0 before the next edge.
  - After release, a tie goes to port 0.
